// File: rtl/approx_err_sweep_checker.sv
// -----------------------------------------------------------------------------
// approx_err_sweep_checker
//
// Walks every input vector of a combinational approximate |a-b| circuit, one
// vector per cycle. It compares each approximate output with the exact
// absolute difference and accumulates the error statistics. When the sweep is
// complete it holds a pass/fail verdict against the error threshold ET.
//
// Operands: a = vec[IN_W/2-1:0], b = vec[IN_W-1:IN_W/2].
//
// Pipeline: the SWEEP state registers {vec_o, approx_i} into stage 1. The
// following edge accumulates that stage-1 entry (stage 2). One DRAIN cycle
// flushes the last entry before the block enters DONE.
//
// Handshake: this block has no valid/ready pair. A start pulse is accepted on
// any rising edge where the FSM is in IDLE or DONE. The block ignores start in
// SWEEP and DRAIN. The statistics are valid while done is high. done stays
// high until the next accepted start or until reset.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     begin a new sweep (sampled in IDLE/DONE only)
//   vec_o     vector driven into the approximate circuit
//   approx_i  approximate circuit output for vec_o, same cycle
//   busy      high in SWEEP and DRAIN
//   done      high in DONE; statistics valid
//   pass      max_err <= ET, gated by done
//   max_err   largest per-vector error seen
//   err_sum   sum of per-vector errors
//   viol_cnt  number of vectors with err > ET
//   state_o   current FSM state (0 IDLE, 1 SWEEP, 2 DRAIN, 3 DONE)
// -----------------------------------------------------------------------------
module approx_err_sweep_checker #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2,
    parameter int ET    = 3,
    parameter int ERR_W = (OUT_W > IN_W / 2) ? OUT_W : IN_W / 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [IN_W-1:0]       vec_o,
    input  logic [OUT_W-1:0]      approx_i,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ERR_W-1:0]      max_err,
    output logic [ERR_W+IN_W-1:0] err_sum,
    output logic [IN_W:0]         viol_cnt,
    output logic [1:0]            state_o
);

    localparam int HW = IN_W / 2;
    localparam logic [IN_W-1:0] VEC_LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [IN_W-1:0]         vec_q;
    logic                    busy_q;
    logic                    done_q;
    logic [IN_W-1:0]         s1_vec_q;
    logic [OUT_W-1:0]        s1_approx_q;
    logic                    s1_valid_q;
    logic [ERR_W-1:0]        max_err_q;
    logic [ERR_W+IN_W-1:0]   err_sum_q;
    logic [IN_W:0]           viol_cnt_q;

    // Stage-2 error datapath, computed from the stage-1 registers.
    logic [HW-1:0]           op_a;
    logic [HW-1:0]           op_b;
    logic [HW-1:0]           exact;
    logic [ERR_W-1:0]        exact_ext;
    logic [ERR_W-1:0]        approx_ext;
    logic [ERR_W-1:0]        err;
    logic                    viol;
    logic [ERR_W-1:0]        max_err_d;
    logic [ERR_W+IN_W-1:0]   err_sum_d;
    logic [IN_W:0]           viol_cnt_d;

    always_comb begin
        op_a       = s1_vec_q[HW-1:0];
        op_b       = s1_vec_q[IN_W-1:HW];
        exact      = (op_a >= op_b) ? (op_a - op_b) : (op_b - op_a);
        exact_ext  = ERR_W'(exact);
        approx_ext = ERR_W'(s1_approx_q);
        err        = (exact_ext >= approx_ext) ? (exact_ext - approx_ext)
                                               : (approx_ext - exact_ext);
        viol       = (int'(err) > ET);
        max_err_d  = (err > max_err_q) ? err : max_err_q;
        err_sum_d  = err_sum_q + (ERR_W + IN_W)'(err);
        viol_cnt_d = viol_cnt_q + (IN_W + 1)'(viol);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            s1_vec_q    <= '0;
            s1_approx_q <= '0;
            s1_valid_q  <= 1'b0;
            max_err_q   <= '0;
            err_sum_q   <= '0;
            viol_cnt_q  <= '0;
        end else begin
            // Stage 2: accumulate whichever entry stage 1 holds.
            if (s1_valid_q) begin
                max_err_q  <= max_err_d;
                err_sum_q  <= err_sum_d;
                viol_cnt_q <= viol_cnt_d;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    // s1_valid_q is always low here, so this clear never
                    // races with an accumulate.
                    if (start) begin
                        max_err_q  <= '0;
                        err_sum_q  <= '0;
                        viol_cnt_q <= '0;
                        vec_q      <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        state_q    <= S_SWEEP;
                    end
                end
                S_SWEEP: begin
                    s1_vec_q    <= vec_q;
                    s1_approx_q <= approx_i;
                    s1_valid_q  <= 1'b1;
                    // Park on the last vector rather than wrapping to 0.
                    if (vec_q == VEC_LAST) begin
                        state_q <= S_DRAIN;
                    end else begin
                        vec_q <= vec_q + 1'b1;
                    end
                end
                S_DRAIN: begin
                    s1_valid_q <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign vec_o    = vec_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign max_err  = max_err_q;
    assign err_sum  = err_sum_q;
    assign viol_cnt = viol_cnt_q;
    assign pass     = done_q && (int'(max_err_q) <= ET);
    assign state_o  = state_q;

endmodule

// File: tb/tb_approx_err_sweep_checker.sv
module tb_approx_err_sweep_checker;

    localparam int IN_W  = 4;
    localparam int OUT_W = 2;
    localparam int ERR_W = 2;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n;
    logic start;
    always #5 clk = ~clk;

    // Approximate-circuit behaviour selector: 0 exact, 1 tied 0, 2 tied 3, 3 returns a
    int mode;

    logic [IN_W-1:0]       vec3, vec2;
    logic [OUT_W-1:0]      ap3, ap2;
    logic                  busy3, busy2, done3, done2, pass3, pass2;
    logic [ERR_W-1:0]      max3, max2;
    logic [ERR_W+IN_W-1:0] sum3, sum2;
    logic [IN_W:0]         viol3, viol2;
    logic [1:0]            st3, st2;

    function automatic logic [1:0] approx_model(input int m, input logic [3:0] v);
        logic [1:0] a, b, d;
        a = v[1:0];
        b = v[3:2];
        d = (a >= b) ? (a - b) : (b - a);
        case (m)
            0:       return d;
            1:       return 2'd0;
            2:       return 2'd3;
            default: return a;
        endcase
    endfunction

    always_comb ap3 = approx_model(mode, vec3);
    always_comb ap2 = approx_model(mode, vec2);

    approx_err_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec3), .approx_i(ap3),
        .busy(busy3), .done(done3), .pass(pass3), .max_err(max3),
        .err_sum(sum3), .viol_cnt(viol3), .state_o(st3)
    );

    approx_err_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .vec_o(vec2), .approx_i(ap2),
        .busy(busy2), .done(done2), .pass(pass2), .max_err(max2),
        .err_sum(sum2), .viol_cnt(viol2), .state_o(st2)
    );

    // Scoreboard counters
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Hand-computed expectations per approximate-circuit mode
    typedef struct {
        int mode;
        int max_e;
        int sum_e;
        int viol_et3;
        int pass_et3;
        int viol_et2;
        int pass_et2;
    } exp_t;

    exp_t tbl[4];

    task automatic check_zero(input string tag);
        chk({tag, "_busy3"}, busy3, 0);
        chk({tag, "_done3"}, done3, 0);
        chk({tag, "_pass3"}, pass3, 0);
        chk({tag, "_max3"}, max3, 0);
        chk({tag, "_sum3"}, sum3, 0);
        chk({tag, "_viol3"}, viol3, 0);
        chk({tag, "_vec3"}, vec3, 0);
        chk({tag, "_done2"}, done2, 0);
        chk({tag, "_sum2"}, sum2, 0);
        chk({tag, "_viol2"}, viol2, 0);
    endtask

    // Launch a sweep from IDLE/DONE and follow it to done.
    // glitch_at: drive start high while vec_o equals this value (-1 for none).
    // hold: keep start high for this many cycles after the accepting edge.
    task automatic run_sweep(input int glitch_at, input int hold);
        int  n;
        int  seen;
        int  vec_ok;
        int  overlap;
        int  exp_vec;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);               // accepting edge E0
        @(negedge clk);
        if (hold == 0) start = 1'b0;
        chk("accept_done", done3, 0);
        chk("accept_busy", busy3, 1);
        chk("accept_vec", vec3, 0);
        chk("accept_max", max3, 0);
        chk("accept_sum", sum3, 0);
        chk("accept_viol2", viol2, 0);
        n = 0;
        seen = 0;
        vec_ok = 1;
        overlap = 0;
        while (n < 40 && seen == 0) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (n == glitch_at) || (n < hold);
            exp_vec = (n <= 15) ? n : 15;
            if (vec3 != 4'(exp_vec) || vec2 != 4'(exp_vec)) vec_ok = 0;
            if ((busy3 && done3) || (busy2 && done2)) overlap = 1;
            if (done3) seen = 1;
        end
        start = 1'b0;
        chk("done_latency", n, 17);
        chk("vec_sequence", vec_ok, 1);
        chk("busy_done_overlap", overlap, 0);
        chk("busy_after_done", busy3, 0);
        chk("state_done", st3, 3);
        chk("done2_aligned", done2, 1);
    endtask

    task automatic check_stats(input int i);
        chk("done_hold", done3, 1);
        chk("max_err_et3", max3, tbl[i].max_e);
        chk("err_sum_et3", sum3, tbl[i].sum_e);
        chk("viol_cnt_et3", viol3, tbl[i].viol_et3);
        chk("pass_et3", pass3, tbl[i].pass_et3);
        chk("max_err_et2", max2, tbl[i].max_e);
        chk("err_sum_et2", sum2, tbl[i].sum_e);
        chk("viol_cnt_et2", viol2, tbl[i].viol_et2);
        chk("pass_et2", pass2, tbl[i].pass_et2);
    endtask

    task automatic abort_test(input int at);
        int n;
        int found;
        int seen;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        found = (vec3 == 4'(at)) ? 1 : 0;
        while (n < 30 && found == 0) begin
            @(negedge clk);
            n++;
            if (vec3 == 4'(at)) found = 1;
        end
        chk("abort_reached", found, 1);
        chk("abort_pre_busy", busy3, 1);
        rst_n = 1'b0;
        #1;
        check_zero("abort");
        chk("abort_state", st3, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done3 || busy3) seen = 1;
        end
        chk("abort_stays_idle", seen, 0);
    endtask

    initial begin
        tbl[0] = '{0, 0, 0,  0, 1, 0, 1};   // exact circuit
        tbl[1] = '{1, 3, 20, 0, 1, 2, 0};   // tied to 0
        tbl[2] = '{2, 3, 28, 0, 1, 4, 0};   // tied to 3, a==b vectors err 3
        tbl[3] = '{3, 3, 18, 0, 1, 2, 0};   // returns operand a

        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        #12;
        check_zero("reset");
        chk("reset_state", st3, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("idle");

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_sweep(-1, 0);
            check_stats(i);
        end

        // start pulsed mid-sweep at vec_o=5 is ignored
        mode = 1;
        run_sweep(5, 0);
        check_stats(1);

        // back-to-back: second sweep accepted with start held high in DONE
        mode = 3;
        run_sweep(-1, 0);
        check_stats(3);
        run_sweep(-1, 3);
        check_stats(3);

        // reset mid-sweep at vec_o=9, then a clean full sweep
        mode = 2;
        abort_test(9);
        run_sweep(-1, 0);
        check_stats(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
